mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that lets the instruction cache and the data cache share one slow_memory instance through a single 128-bit line port. It sits between the two cache miss interfaces of CHIP and the slow_memory protocol (read/write/addr[31:4]/wdata/rdata/ready). It serves one line transaction at a time, using round-robin priority, latched request capture and a watchdog on memory latency.

## Interface
- TIMEOUT, 64, cycles in a grant without mem_ready before timeout_err sets (≥2)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_read  in  1  I-cache line read request
- i_write  in  1  I-cache line write request (normally 0)
- i_addr  in  28  I-cache line address [31:4]
- i_wdata  in  128  I-cache write line
- i_rdata  out  128  read line to I-cache
- i_ready  out  1  I-cache transaction complete
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write (write-back) request
- d_addr  in  28  D-cache line address [31:4]
- d_wdata  in  128  D-cache write line
- d_rdata  out  128  read line to D-cache
- d_ready  out  1  D-cache transaction complete
- mem_read  out  1  to slow_memory
- mem_write  out  1  to slow_memory
- mem_addr  out  28  to slow_memory
- mem_wdata  out  128  to slow_memory
- mem_rdata  in  128  from slow_memory
- mem_ready  in  1  from slow_memory, one-cycle completion pulse
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, GNT_I, GNT_D. Request of a port = read | write.
- IDLE: no request → stay. One request → grant that port. Both → grant port ≠ last_grant. last_grant resets to I, so first tie goes to D.
- On grant edge, latch the granted port's read, write, addr and wdata into output registers. mem_* are driven only from these registers. Requester changes or drops during the grant have no effect.
- If read and write are both set, both are forwarded as latched. The memory's behaviour governs.
- GNT_x: hold until mem_ready=1. On that edge: → IDLE, clear mem_read/mem_write/mem_addr/mem_wdata to 0, last_grant ← x.
- x_ready = mem_ready & (state==GNT_x), combinational. The other port's ready is 0.
- i_rdata = d_rdata = mem_rdata, passthrough. Valid only when the matching ready is high.
- mem_ready in IDLE is ignored.
- Watchdog: counter clears on grant and increments each cycle in GNT_x, saturating. It sets timeout_err when it reaches TIMEOUT without mem_ready. timeout_err stays set until reset. The grant is not aborted.
- Reset asserted at any time, including mid-grant: state→IDLE, last_grant→I, counter→0. mem_read, mem_write, mem_addr, mem_wdata and timeout_err → 0 immediately. i_ready and d_ready → 0.

## Timing
- Request visible in IDLE cycle t → mem_read/mem_write high in cycle t+1.
- mem_ready in cycle n → x_ready high in cycle n, same cycle. mem_* low from cycle n+1.
- Cycle n+1 is IDLE and samples requests, which reflect the cache's post-ready state. The next grant's request appears at cycle n+2.
- Minimum turnaround is 1 idle cycle between transactions. The arbitration overhead is 1 cycle per transaction.
- Under continuous requests from both ports, grants strictly alternate. No port waits more than one other transaction.
- timeout_err rises in the cycle after the counter reaches TIMEOUT. With mem_ready never asserted, that is the edge ending the TIMEOUT-th grant cycle.

## Test plan
- Lone D read, d_addr=28'h0000010, memory ready 5 cycles after mem_read → mem_read=1 and mem_addr=28'h0000010 one cycle after the request. d_ready pulses once, coincident with mem_ready, and d_rdata=mem_rdata. i_ready stays 0.
- After reset, i_read and d_write asserted in the same cycle, d_wdata=128'hA5…A5 → D granted first with mem_write=1 and mem_wdata=128'hA5…A5. After d_ready, one idle cycle, then the I read is granted.
- Both ports requesting continuously for 6 transactions → grant order D,I,D,I,D,I. Each ready goes only to the granted port.
- During GNT_I, i_addr changes 28'h100→28'h200 and i_read drops → mem_addr stays 28'h100 and mem_read stays 1 until mem_ready. i_ready still pulses.
- TIMEOUT=8, memory never ready → timeout_err=0 through grant cycle 8, then 1. It stays 1 while the state holds GNT_x, and clears only on rst_n=0.
- rst_n pulled low mid-GNT_D → all outputs 0 before the next clock edge. After release, a simultaneous I/D request grants D.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D cache line arbiter in front of slow_memory.
// Latches one request per grant, forwards it to memory, watchdogs latency.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_read/i_write/i_addr/i_wdata   I-cache line request
//   i_rdata/i_ready                 I-cache response
//   d_read/d_write/d_addr/d_wdata   D-cache line request
//   d_rdata/d_ready                 D-cache response
//   mem_read/mem_write/mem_addr/
//   mem_wdata                       registered request to slow_memory
//   mem_rdata/mem_ready             slow_memory response
//   timeout_err                     sticky latency watchdog flag
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_read,
  input  logic         i_write,
  input  logic [27:0]  i_addr,
  input  logic [127:0] i_wdata,
  output logic [127:0] i_rdata,
  output logic         i_ready,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [27:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic         timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_HIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_d_q, last_d_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [27:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic           terr_q, terr_d;

  logic i_req, d_req;
  logic pick_i, pick_d;

  assign i_req = i_read | i_write;
  assign d_req = d_read | d_write;

  // On a tie the port that did not win last time is served.
  assign pick_d = d_req & (~i_req | ~last_d_q);
  assign pick_i = i_req & ~pick_d;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    terr_d   = terr_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_d: begin
            state_d = GNT_D;
            cnt_d   = '0;
            rd_d    = d_read;
            wr_d    = d_write;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end
          pick_i: begin
            state_d = GNT_I;
            cnt_d   = '0;
            rd_d    = i_read;
            wr_d    = i_write;
            addr_d  = i_addr;
            wdata_d = i_wdata;
          end
          default: ;
        endcase
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          state_d  = IDLE;
          last_d_d = (state_q == GNT_D);
          rd_d     = 1'b0;
          wr_d     = 1'b0;
          addr_d   = '0;
          wdata_d  = '0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          // Flag on the edge where the count would reach TIMEOUT.
          if (cnt_q >= CNT_HIT) terr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      terr_q   <= terr_d;
    end
  end

  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign timeout_err = terr_q;

  assign i_ready = mem_ready & (state_q == GNT_I);
  assign d_ready = mem_ready & (state_q == GNT_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Transaction-level reference model, cache agents and a memory model.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_read = 1'b0, i_write = 1'b0;
  logic [27:0]  i_addr = '0;
  logic [127:0] i_wdata = '0;
  logic [127:0] i_rdata;
  logic         i_ready;
  logic         d_read = 1'b0, d_write = 1'b0;
  logic [27:0]  d_addr = '0;
  logic [127:0] d_wdata = '0;
  logic [127:0] d_rdata;
  logic         d_ready;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic         timeout_err;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write),
    .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           port;
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  bit   glog[$];
  int   tests = 0;
  int   fails = 0;

  bit m_busy = 0, m_owner = 0, m_last = 0, m_terr = 0;
  int m_age = 0;

  bit i_pend = 0, d_pend = 0, i_done = 0, d_done = 0;
  bit auto_on = 0, scram = 0, spur = 0, never = 0;
  int rate = 0;
  int fixed_lat = -1;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: one transaction at a time, round robin on ties.
  initial begin : model
    txn_t t;
    bit ri, rq;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 0; m_last = 0; m_terr = 0; m_age = 0;
        exp_q.delete();
      end else if (!m_busy) begin
        ri = i_read | i_write;
        rq = d_read | d_write;
        if (ri || rq) begin
          t.port = (ri && rq) ? ~m_last : rq;
          if (t.port) begin
            t.rd = d_read; t.wr = d_write;
            t.addr = d_addr; t.wdata = d_wdata;
          end else begin
            t.rd = i_read; t.wr = i_write;
            t.addr = i_addr; t.wdata = i_wdata;
          end
          exp_q.push_back(t);
          m_busy = 1; m_owner = t.port; m_age = 0;
        end
      end else if (mem_ready) begin
        m_busy = 0;
        m_last = m_owner;
      end else begin
        m_age++;
        if (m_age >= TO) m_terr = 1;
      end
    end
  end

  // Monitor: pops the expected transaction when the DUT starts one.
  initial begin : monitor
    txn_t cur;
    bit cur_v;
    cur_v = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_v = 0; i_done = 0; d_done = 0;
      end else begin
        chk("mem_active", mem_read | mem_write, m_busy);
        chk("timeout_err", timeout_err, m_terr);
        if ((mem_read | mem_write) && !cur_v) begin
          chk("grant_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            cur_v = 1;
            glog.push_back(cur.port);
          end
        end
        if (cur_v) begin
          chk("mem_read", mem_read, cur.rd);
          chk("mem_write", mem_write, cur.wr);
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wdata", mem_wdata, cur.wdata);
        end else begin
          chk("idle_addr", mem_addr, 0);
          chk("idle_wdata", mem_wdata, 0);
        end
        chk("i_ready", i_ready, m_busy && mem_ready && !m_owner);
        chk("d_ready", d_ready, m_busy && mem_ready && m_owner);
        if (i_ready) chk("i_rdata", i_rdata, mem_rdata);
        if (d_ready) chk("d_rdata", d_rdata, mem_rdata);
        if (mem_ready && cur_v) cur_v = 0;
        if (i_ready) i_done = 1;
        if (d_ready) d_done = 1;
      end
    end
  end

  // Memory model: random or fixed latency, optional stray ready pulses.
  initial begin : memory
    bit in_txn;
    int lat;
    in_txn = 0; lat = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mem_ready = 0; in_txn = 0;
      end else if (mem_ready) begin
        mem_ready = 0; in_txn = 0;
      end else if (mem_read | mem_write) begin
        if (!in_txn) begin
          in_txn = 1;
          lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(4));
        end
        if (!never) begin
          if (lat == 0) begin
            mem_ready = 1; mem_rdata = rnd128();
          end else lat--;
        end
      end else if (spur && $urandom_range(9) == 0) begin
        mem_ready = 1; mem_rdata = rnd128();
      end
    end
  end

  task automatic new_i();
    i_write = ($urandom_range(9) == 0);
    i_read = ~i_write;
    i_addr = 28'($urandom);
    i_wdata = rnd128();
    i_pend = 1;
  endtask

  task automatic new_d();
    int r;
    r = int'($urandom_range(15));
    d_read = (r < 8) || (r == 15);
    d_write = (r >= 8);
    d_addr = 28'($urandom);
    d_wdata = rnd128();
    d_pend = 1;
  endtask

  // Cache agents: hold a request until its ready, then drop or reissue.
  initial begin : agents
    int r;
    forever begin
      @(posedge clk); #1;
      if (i_done) begin
        i_done = 0; i_pend = 0; i_read = 0; i_write = 0;
      end
      if (d_done) begin
        d_done = 0; d_pend = 0; d_read = 0; d_write = 0;
      end
      if (auto_on) begin
        if (!i_pend) begin
          if (int'($urandom_range(99)) < rate) new_i();
        end else if (scram) begin
          r = int'($urandom_range(15));
          if (r == 0) begin
            i_read = 0; i_write = 0; i_pend = 0;
          end else if (r < 3) begin
            i_addr = 28'($urandom); i_wdata = rnd128();
          end
        end
        if (!d_pend) begin
          if (int'($urandom_range(99)) < rate) new_d();
        end else if (scram) begin
          r = int'($urandom_range(15));
          if (r == 0) begin
            d_read = 0; d_write = 0; d_pend = 0;
          end else if (r < 3) begin
            d_addr = 28'($urandom); d_wdata = rnd128();
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 0;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_pend = 0; d_pend = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while ((i_pend || d_pend || m_busy) && n < budget) begin
      step(); n++;
    end
    chk("wait_done", i_pend || d_pend || m_busy, 0);
  endtask

  task automatic wait_grants(int cnt, int budget);
    int n;
    n = 0;
    while (glog.size() < cnt && n < budget) begin
      step(); n++;
    end
    chk("wait_grants", glog.size() >= cnt, 1);
  endtask

  task automatic wait_active(int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(mem_read | mem_write) && n < budget) begin
      @(negedge clk); n++;
    end
    chk("wait_active", mem_read | mem_write, 1);
  endtask

  logic [127:0] a5;

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    a5 = {16{8'hA5}};
    do_reset();
    step();
    chk("rst_mem_read", mem_read, 0);
    chk("rst_terr", timeout_err, 0);

    // Lone D read with a 5-cycle memory.
    fixed_lat = 5;
    glog.delete();
    d_read = 1; d_addr = 28'h0000010; d_pend = 1;
    wait_done(40);
    chk("lone_cnt", glog.size(), 1);
    chk("lone_port", glog[0], 1);

    // Simultaneous I read / D write right after reset.
    do_reset();
    step();
    glog.delete();
    fixed_lat = 3;
    i_read = 1; i_addr = 28'h100; i_pend = 1;
    d_write = 1; d_addr = 28'h20; d_wdata = a5; d_pend = 1;
    wait_done(60);
    chk("tie_cnt", glog.size(), 2);
    chk("tie_first_d", glog[0], 1);
    chk("tie_second_i", glog[1], 0);

    // Continuous requests from both ports alternate.
    glog.delete();
    fixed_lat = 2;
    rate = 100; scram = 0; auto_on = 1;
    wait_grants(6, 100);
    auto_on = 0;
    for (int k = 0; k < 6; k++)
      chk($sformatf("alt_order%0d", k), glog[k], (k % 2) == 0);
    wait_done(60);

    // Requester changes mid-grant are ignored.
    glog.delete();
    fixed_lat = 4;
    step();
    i_read = 1; i_addr = 28'h100; i_pend = 1;
    wait_active(10);
    step();
    i_addr = 28'h200; i_read = 0;
    @(negedge clk);
    chk("hold_addr", mem_addr, 28'h100);
    chk("hold_read", mem_read, 1);
    wait_done(40);
    chk("hold_port", glog[0], 0);

    // Randomised traffic with stray ready pulses.
    fixed_lat = -1;
    rate = 30; scram = 1; spur = 1; auto_on = 1;
    repeat (1500) step();
    auto_on = 0; spur = 0;
    wait_done(200);

    // Watchdog: memory never answers.
    never = 1;
    step();
    d_read = 1; d_addr = 28'h30; d_pend = 1;
    wait_active(10);
    for (int k = 1; k <= TO; k++) begin
      chk($sformatf("terr_low_c%0d", k), timeout_err, 0);
      @(negedge clk);
    end
    for (int k = TO + 1; k <= TO + 4; k++) begin
      chk($sformatf("terr_high_c%0d", k), timeout_err, 1);
      chk("terr_still_gnt", mem_read, 1);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of the stuck D grant.
    @(posedge clk);
    #2 rst_n = 0;
    #1 mem_ready = 1;
    #1;
    chk("arst_mem_read", mem_read, 0);
    chk("arst_mem_write", mem_write, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_terr", timeout_err, 0);
    chk("arst_i_ready", i_ready, 0);
    chk("arst_d_ready", d_ready, 0);
    mem_ready = 0;
    never = 0;
    fixed_lat = 1;
    d_read = 0; d_pend = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    step();
    glog.delete();
    i_read = 1; i_addr = 28'h44; i_pend = 1;
    d_read = 1; d_addr = 28'h55; d_pend = 1;
    wait_done(40);
    chk("post_rst_first_d", glog[0], 1);
    chk("post_rst_cnt", glog.size(), 2);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
